// File: rtl/ddr4_v2_2_axi_cmd_seq_fsm.sv
// Command sequencer for one AXI address channel (AR or AW) of the DDR4 MC front end.
// Accepts an address handshake, steps the burst translators per MC command and tracks credits.
module ddr4_v2_2_axi_cmd_seq_fsm #(
  parameter int  C_MAX_OUTSTANDING = 8,
  parameter int  C_MC_RD_INST      = 0,
  localparam int P_CNT_W           = $clog2(C_MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               axvalid,
  output logic               axready,
  output logic               axhandshake,
  input  logic               next_pending,
  output logic               next,
  output logic               cmd_en,
  input  logic               mc_rdy,
  input  logic               data_rdy,
  input  logic               cmd_cpl,
  output logic [P_CNT_W-1:0] outstanding,
  output logic               busy
);

  localparam logic [P_CNT_W-1:0] MAX_CNT = P_CNT_W'(C_MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_e;

  state_e             state_q, state_d;
  logic               axready_q, axready_d;
  logic [P_CNT_W-1:0] cnt_q, cnt_d;
  logic               data_ok;
  logic               credit_ok;
  logic               cpl_dec;
  logic               cpl_underflow;

  // Read: room in the R buffer; write: W data already present. Both gate issue identically.
  if (C_MC_RD_INST != 0) begin : g_rd_chan
    assign data_ok = data_rdy;
  end else begin : g_wr_chan
    assign data_ok = data_rdy;
  end

  always_comb begin
    credit_ok     = (cnt_q < MAX_CNT);
    axhandshake   = axvalid & axready_q;
    // HOLD keeps the credit and data slot reserved when the command was first offered.
    cmd_en        = (state_q == S_HOLD) |
                    ((state_q == S_ISSUE) & data_ok & credit_ok);
    next          = cmd_en & mc_rdy;
    cpl_dec       = cmd_cpl & (cnt_q != '0);
    cpl_underflow = cmd_cpl & (cnt_q == '0);

    unique case ({next, cpl_dec})
      2'b10:   cnt_d = cnt_q + P_CNT_W'(1);
      2'b01:   cnt_d = cnt_q - P_CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    state_d   = state_q;
    axready_d = axready_q;
    unique case (state_q)
      S_IDLE: begin
        if (axhandshake) begin
          state_d   = S_ISSUE;
          axready_d = 1'b0;
        end else begin
          axready_d = (cnt_d < MAX_CNT);
        end
      end
      S_ISSUE, S_HOLD: begin
        if (next) begin
          if (next_pending) begin
            state_d = S_ISSUE;
          end else begin
            state_d   = S_IDLE;
            axready_d = (cnt_d < MAX_CNT);
          end
        end else if (cmd_en) begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d   = S_IDLE;
        axready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      axready_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      axready_q <= axready_d;
      cnt_q     <= cnt_d;
    end
  end

  assign axready     = axready_q;
  assign outstanding = cnt_q;
  assign busy        = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(axhandshake && next));
      assert (cnt_q <= MAX_CNT);
    end
  end

`ifdef DDR4_AXI_SEQ_CHK_UNDERFLOW
  // A completion with nothing in flight is an upstream bug; the counter saturates regardless.
  always_ff @(posedge clk) begin
    if (reset_n) assert (!cpl_underflow);
  end
`endif

endmodule
